// File: rtl/qbus_virq_arbiter.sv
// QBUS vectored-interrupt arbiter: pending capture, VIRQ, IAKO/DIN vector reply, daisy-chain pass.
// Optional rotating priority when QBUS_VIRQ_ROUNDROBIN_EN is defined; fixed priority otherwise.
module qbus_virq_arbiter #(
  parameter int NREQ     = 4,
  parameter int RPLY_DLY = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     irq_req,
  input  logic [NREQ*9-1:0]   irq_vec,
  output logic [NREQ-1:0]     irq_ack,
  output logic                virq_n,
  input  logic                iako_n,
  input  logic                din_n,
  output logic                iako_out_n,
  output logic [15:0]         ad_out,
  output logic                ad_oe,
  output logic                rply_n
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, REPLY, PASS} state_t;

  state_t          state_q, state_d;
  logic [1:0]      iako_sync_q, din_sync_q;
  logic            siako, sdin;
  logic [NREQ-1:0] req_prev_q, pending_q, pending_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [IW-1:0]   win_q, win_d, sel;
  logic [3:0]      cnt_q, cnt_d;
  logic [15:0]     ad_out_q, ad_out_d;
  logic            ad_oe_q, ad_oe_d;
  logic            rply_n_q, rply_n_d;
  logic            iako_out_n_q, iako_out_n_d;
  logic            virq_n_q;
  logic [8:0]      vec_arr [NREQ];
`ifdef QBUS_VIRQ_ROUNDROBIN_EN
  logic [IW-1:0]   ptr_q, ptr_d;
`endif

  assign siako = iako_sync_q[1];
  assign sdin  = din_sync_q[1];

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      vec_arr[i] = irq_vec[9*i +: 9];
    end
  end

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    sel = '0;
    for (int unsigned k = NREQ; k > 0; k--) begin
`ifdef QBUS_VIRQ_ROUNDROBIN_EN
      if (pending_q[IW'((ptr_q + k - 1) % NREQ)]) sel = IW'((ptr_q + k - 1) % NREQ);
`else
      if (pending_q[IW'(k - 1)]) sel = IW'(k - 1);
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    cnt_d        = cnt_q;
    ad_out_d     = ad_out_q;
    ad_oe_d      = ad_oe_q;
    rply_n_d     = rply_n_q;
    iako_out_n_d = iako_out_n_q;
    ack_d        = '0;
`ifdef QBUS_VIRQ_ROUNDROBIN_EN
    ptr_d        = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (!siako && !sdin) begin
          if (|pending_q) begin
            win_d    = sel;
            ad_out_d = {7'b0, vec_arr[sel]};
            cnt_d    = 4'(RPLY_DLY);
            state_d  = WAIT;
          end else begin
            iako_out_n_d = 1'b0;
            state_d      = PASS;
          end
        end
      end
      WAIT: begin
        if (sdin) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          rply_n_d = 1'b0;
          ad_oe_d  = 1'b1;
          ack_d    = NREQ'(1) << win_q;
          state_d  = REPLY;
`ifdef QBUS_VIRQ_ROUNDROBIN_EN
          ptr_d    = (int'(win_q) == NREQ - 1) ? '0 : win_q + 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      REPLY: begin
        if (sdin) begin
          rply_n_d = 1'b1;
          ad_oe_d  = 1'b0;
          state_d  = IDLE;
        end
      end
      PASS: begin
        if (siako || sdin) begin
          iako_out_n_d = 1'b1;
          state_d      = IDLE;
        end else begin
          iako_out_n_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new rising edge on the grant cycle re-arms the flag.
  assign pending_d = (pending_q & ~ack_d) | (irq_req & ~req_prev_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      iako_sync_q  <= '1;
      din_sync_q   <= '1;
      req_prev_q   <= '0;
      pending_q    <= '0;
      ack_q        <= '0;
      win_q        <= '0;
      cnt_q        <= '0;
      ad_out_q     <= '0;
      ad_oe_q      <= 1'b0;
      rply_n_q     <= 1'b1;
      iako_out_n_q <= 1'b1;
      virq_n_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      iako_sync_q  <= {iako_sync_q[0], iako_n};
      din_sync_q   <= {din_sync_q[0], din_n};
      req_prev_q   <= irq_req;
      pending_q    <= pending_d;
      ack_q        <= ack_d;
      win_q        <= win_d;
      cnt_q        <= cnt_d;
      ad_out_q     <= ad_out_d;
      ad_oe_q      <= ad_oe_d;
      rply_n_q     <= rply_n_d;
      iako_out_n_q <= iako_out_n_d;
      virq_n_q     <= ~(|pending_q);
    end
  end

`ifdef QBUS_VIRQ_ROUNDROBIN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`endif

  assign irq_ack    = ack_q;
  assign virq_n     = virq_n_q;
  assign iako_out_n = iako_out_n_q;
  assign ad_out     = ad_out_q;
  assign ad_oe      = ad_oe_q;
  assign rply_n     = rply_n_q;

endmodule

// File: tb/tb_qbus_virq_arbiter.sv
// Scoreboard bench for qbus_virq_arbiter: expected vector/ack queued per vector cycle, checked at RPLY.
module tb_qbus_virq_arbiter;

  localparam int NREQ     = 4;
  localparam int RPLY_DLY = 2;
  localparam int LAT      = 4 + RPLY_DLY;  // 2 sync edges + detection + RPLY_DLY + 1

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   irq_req;
  logic [NREQ*9-1:0] irq_vec;
  logic [NREQ-1:0]   irq_ack;
  logic              virq_n;
  logic              iako_n;
  logic              din_n;
  logic              iako_out_n;
  logic [15:0]       ad_out;
  logic              ad_oe;
  logic              rply_n;

  typedef struct packed {
    logic [8:0]      vec;
    logic [NREQ-1:0] ack;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_errors = 0;
  logic rply_prev = 1'b1;
  logic [NREQ-1:0] ack_prev = '0;

  qbus_virq_arbiter #(.NREQ(NREQ), .RPLY_DLY(RPLY_DLY)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_req    (irq_req),
    .irq_vec    (irq_vec),
    .irq_ack    (irq_ack),
    .virq_n     (virq_n),
    .iako_n     (iako_n),
    .din_n      (din_n),
    .iako_out_n (iako_out_n),
    .ad_out     (ad_out),
    .ad_oe      (ad_oe),
    .rply_n     (rply_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_vec(input int i, input logic [8:0] v);
    irq_vec[9*i +: 9] = v;
  endtask

  // Full vector cycle; raise_at >= 1 re-raises irq_req[0] at that negedge count.
  task automatic vcycle(input int raise_at, input logic [8:0] evec, input logic [NREQ-1:0] eack);
    int n;
    bit got;
    exp_t x;
    x.vec = evec;
    x.ack = eack;
    sb.push_back(x);
    iako_n = 1'b0;
    din_n  = 1'b0;
    n = 0;
    got = 0;
    while (n < 40 && !got) begin
      @(negedge clk);
      n++;
      if (rply_n == 1'b0) got = 1;
      else if (n == raise_at) irq_req[0] = 1'b1;
    end
    check("rply_latency", n, LAT);
    iako_n = 1'b1;
    din_n  = 1'b1;
    n = 0;
    while (n < 40 && rply_n !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    check("rply_release", rply_n, 1'b1);
    check("ad_oe_release", ad_oe, 1'b0);
    cycles(2);
  endtask

  always @(negedge clk) begin
    if (rply_prev === 1'b1 && rply_n === 1'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_rply", rply_n, 1'b1);
      end else begin
        e = sb.pop_front();
        check("ad_out", ad_out, {7'b0, e.vec});
        check("irq_ack", irq_ack, e.ack);
        check("ad_oe", ad_oe, 1'b1);
      end
    end
    if (ack_prev != '0) check("ack_pulse", irq_ack, '0);
    rply_prev = rply_n;
    ack_prev  = irq_ack;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    irq_req = '0;
    irq_vec = '0;
    iako_n  = 1'b1;
    din_n   = 1'b1;
    cycles(3);
    check("rst_virq_n", virq_n, 1'b1);
    check("rst_rply_n", rply_n, 1'b1);
    check("rst_ad_oe", ad_oe, 1'b0);
    check("rst_ad_out", ad_out, 16'h0);
    check("rst_iako_out_n", iako_out_n, 1'b1);
    check("rst_irq_ack", irq_ack, '0);
    reset = 1'b0;
    cycles(2);

    // 1: single request, vector 064
    set_vec(0, 9'o064);
    set_vec(1, 9'o060);
    set_vec(2, 9'o070);
    set_vec(3, 9'o100);
    irq_req = 4'b0001;
    cycles(2);
    check("s1_virq_low", virq_n, 1'b0);
    vcycle(-1, 9'o064, 4'b0001);
    check("s1_virq_back", virq_n, 1'b1);
    irq_req = '0;
    cycles(2);

    // 2: nothing pending -> IAKO passed down the chain
    iako_n = 1'b0;
    din_n  = 1'b0;
    cycles(4);
    check("s2_iako_out_low", iako_out_n, 1'b0);
    cycles(3);
    check("s2_iako_out_hold", iako_out_n, 1'b0);
    check("s2_rply_n", rply_n, 1'b1);
    check("s2_ad_oe", ad_oe, 1'b0);
    iako_n = 1'b1;
    din_n  = 1'b1;
    cycles(4);
    check("s2_iako_out_rel", iako_out_n, 1'b1);

    // 3: simultaneous requests 1 and 2, served in order
    irq_req = 4'b0110;
    cycles(3);
    vcycle(-1, 9'o060, 4'b0010);
    check("s3_virq_still", virq_n, 1'b0);
    vcycle(-1, 9'o070, 4'b0100);
    check("s3_virq_done", virq_n, 1'b1);
    irq_req = '0;
    cycles(2);

    // 4: DIN released in WAIT -> abort, pending kept
    irq_req = 4'b1000;
    cycles(3);
    iako_n = 1'b0;
    din_n  = 1'b0;
    cycles(2);
    iako_n = 1'b1;
    din_n  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("s4_no_rply", rply_n, 1'b1);
      check("s4_no_ack", irq_ack, '0);
      check("s4_virq_kept", virq_n, 1'b0);
    end
    vcycle(-1, 9'o100, 4'b1000);
    check("s4_virq_done", virq_n, 1'b1);
    irq_req = '0;
    cycles(2);

    // 6: irq_req[0] re-rises on its own grant cycle
    irq_req[0] = 1'b1;
    cycles(2);
    irq_req[0] = 1'b0;
    cycles(2);
    vcycle(LAT - 1, 9'o064, 4'b0001);
    check("s6_virq_kept", virq_n, 1'b0);
    irq_req = '0;
    vcycle(-1, 9'o064, 4'b0001);
    check("s6_virq_done", virq_n, 1'b1);

    // 5: asynchronous reset while in REPLY
    irq_req = 4'b0110;
    cycles(3);
    irq_req = '0;
    begin
      int n;
      e.vec = 9'o060;
      e.ack = 4'b0010;
      sb.push_back(e);
      iako_n = 1'b0;
      din_n  = 1'b0;
      n = 0;
      while (n < 40 && rply_n !== 1'b0) begin
        @(negedge clk);
        n++;
      end
      check("s5_rply_seen", rply_n, 1'b0);
    end
    @(negedge clk);
    check("s5_in_reply_virq", virq_n, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("s5_rst_rply_n", rply_n, 1'b1);
    check("s5_rst_ad_oe", ad_oe, 1'b0);
    check("s5_rst_virq_n", virq_n, 1'b1);
    check("s5_rst_ad_out", ad_out, 16'h0);
    check("s5_rst_ack", irq_ack, '0);
    iako_n = 1'b1;
    din_n  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cycles(5);
    check("s5_pending_cleared", virq_n, 1'b1);
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
